// File: rtl/park_allocator.sv
// Entry-side slot allocator for the parking controller: hands out the lowest free
// slot of eight as an XOR-scrambled token and frees slots on decrypted exits.
module park_allocator #(
  parameter logic [2:0] PATTERN_SEED = 3'b101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter,
  input  logic       exit,
  input  logic [2:0] park_number,
  output logic [2:0] token,
  output logic       token_valid,
  output logic [2:0] pattern,
  output logic       reject,
  output logic       exit_err,
  output logic       full,
  output logic       empty,
  output logic [3:0] free_count
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [2:0] SEED = (PATTERN_SEED == 3'b000) ? 3'b001 : PATTERN_SEED;

  typedef enum logic {
    IDLE,
    ALLOC_ISSUE
  } state_t;

  state_t     state;
  logic [7:0] occupancy;
  logic [2:0] alloc_slot;
  logic [2:0] lowest_free;
  logic [3:0] occ_count;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] occ_next;
  logic       exit_hit;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    lowest_free = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occupancy[i]) lowest_free = 3'(i);
    end
  end

  always_comb begin
    occ_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      occ_count = occ_count + {3'b000, occupancy[i]};
    end
  end

  assign full       = &occupancy;
  assign empty      = ~|occupancy;
  assign free_count = 4'd8 - occ_count;
  assign exit_hit   = exit && occupancy[park_number];

  // An allocation and an exit may land on the same edge; both masks apply together.
  always_comb begin
    set_mask = 8'h00;
    clr_mask = 8'h00;
    if (state == ALLOC_ISSUE) set_mask[alloc_slot] = 1'b1;
    if (exit_hit) clr_mask[park_number] = 1'b1;
    occ_next = (occupancy & ~clr_mask) | set_mask;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      occupancy   <= 8'h00;
      alloc_slot  <= 3'd0;
      token       <= 3'd0;
      token_valid <= 1'b0;
      reject      <= 1'b0;
      exit_err    <= 1'b0;
      pattern     <= SEED;
    end else begin
      token_valid <= 1'b0;
      reject      <= 1'b0;
      exit_err    <= exit && !occupancy[park_number];
      occupancy   <= occ_next;

      // Rotate only once the lot drains, so outstanding tokens stay decryptable.
      if (exit_hit && (occ_next == 8'h00)) begin
        pattern <= {pattern[1:0], pattern[2] ^ pattern[1]};
      end

      case (state)
        IDLE: begin
          if (enter) begin
            if (full) begin
              reject <= 1'b1;
            end else begin
              alloc_slot <= lowest_free;
              state      <= ALLOC_ISSUE;
            end
          end
        end
        ALLOC_ISSUE: begin
          token       <= alloc_slot ^ pattern;
          token_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_park_allocator.sv
// Self-checking bench for park_allocator: cycle vectors for the fill/full phase,
// hand sequences for exits, pattern rotation and mid-allocation reset.
module tb_park_allocator;

  logic       clk;
  logic       rst_n;
  logic       enter;
  logic       exit;
  logic [2:0] park_number;
  logic [2:0] token;
  logic       token_valid;
  logic [2:0] pattern;
  logic       reject;
  logic       exit_err;
  logic       full;
  logic       empty;
  logic [3:0] free_count;

  int errors = 0;
  int checks = 0;

  logic [2:0] sb[$];
  logic [2:0] exp_tok;

  typedef struct {
    logic       enter;
    logic       exit;
    logic [2:0] pn;
    logic       push;
    logic [2:0] push_tok;
    logic       tv;
    logic       rej;
    logic       err;
    logic [3:0] fc;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vecs[19];
  logic [2:0] toks[8];

  park_allocator #(.PATTERN_SEED(3'b101)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enter       (enter),
    .exit        (exit),
    .park_number (park_number),
    .token       (token),
    .token_valid (token_valid),
    .pattern     (pattern),
    .reject      (reject),
    .exit_err    (exit_err),
    .full        (full),
    .empty       (empty),
    .free_count  (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic x, input logic [2:0] pn);
    enter       = e;
    exit        = x;
    park_number = pn;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Scoreboard: each issued token must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && token_valid) begin
      if (sb.size() == 0) begin
        check("token_unexpected", {31'd0, token_valid}, 32'd0);
      end else begin
        exp_tok = sb.pop_front();
        check("token", {29'd0, token}, {29'd0, exp_tok});
      end
    end
  end

  initial begin
    toks = '{3'b101, 3'b100, 3'b111, 3'b110, 3'b001, 3'b000, 3'b011, 3'b010};
    for (int i = 0; i < 16; i++) begin
      vecs[i].enter    = 1'b1;
      vecs[i].exit     = 1'b0;
      vecs[i].pn       = 3'd0;
      vecs[i].push     = (i % 2 == 0);
      vecs[i].push_tok = toks[i / 2];
      vecs[i].tv       = (i % 2 == 1);
      vecs[i].rej      = 1'b0;
      vecs[i].err      = 1'b0;
      vecs[i].fc       = 4'(8 - (i + 1) / 2);
      vecs[i].full     = (i == 15);
      vecs[i].empty    = (i == 0);
    end
    for (int i = 16; i < 19; i++) begin
      vecs[i].enter    = (i != 18);
      vecs[i].exit     = 1'b0;
      vecs[i].pn       = 3'd0;
      vecs[i].push     = 1'b0;
      vecs[i].push_tok = 3'd0;
      vecs[i].tv       = 1'b0;
      vecs[i].rej      = (i != 18);
      vecs[i].err      = 1'b0;
      vecs[i].fc       = 4'd0;
      vecs[i].full     = 1'b1;
      vecs[i].empty    = 1'b0;
    end

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_token", {29'd0, token}, 32'd0);
    check("rst_token_valid", {31'd0, token_valid}, 32'd0);
    check("rst_reject", {31'd0, reject}, 32'd0);
    check("rst_exit_err", {31'd0, exit_err}, 32'd0);
    check("rst_pattern", {29'd0, pattern}, 32'h5);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_free_count", {28'd0, free_count}, 32'd8);
    rst_n = 1'b1;
    step();

    // Single entry: token one cycle after acceptance, then held.
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b101);
    step();
    check("t1_accept_tv", {31'd0, token_valid}, 32'd0);
    drive(1'b0, 1'b0, 3'd0);
    step();
    check("t1_issue_tv", {31'd0, token_valid}, 32'd1);
    check("t1_free_count", {28'd0, free_count}, 32'd7);
    check("t1_empty", {31'd0, empty}, 32'd0);
    step();
    check("t1_tv_drop", {31'd0, token_valid}, 32'd0);
    check("t1_token_hold", {29'd0, token}, 32'h5);

    // Fill from empty with enter held, then reject while full.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].enter, vecs[i].exit, vecs[i].pn);
      if (vecs[i].push) sb.push_back(vecs[i].push_tok);
      step();
      check($sformatf("vec%0d_tv", i), {31'd0, token_valid}, {31'd0, vecs[i].tv});
      check($sformatf("vec%0d_reject", i), {31'd0, reject}, {31'd0, vecs[i].rej});
      check($sformatf("vec%0d_exit_err", i), {31'd0, exit_err}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_free_count", i), {28'd0, free_count}, {28'd0, vecs[i].fc});
      check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].full});
      check($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, vecs[i].empty});
    end

    // Free slot 3 from a full lot and re-allocate it.
    drive(1'b0, 1'b1, 3'd3);
    step();
    check("t3_free_count", {28'd0, free_count}, 32'd1);
    check("t3_full", {31'd0, full}, 32'd0);
    check("t3_exit_err", {31'd0, exit_err}, 32'd0);
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b110);
    step();
    drive(1'b0, 1'b0, 3'd0);
    step();
    check("t3_tv", {31'd0, token_valid}, 32'd1);
    check("t3_refull", {31'd0, full}, 32'd1);

    // Exit for a slot that is already free.
    drive(1'b0, 1'b1, 3'd6);
    step();
    check("t4_first_exit_err", {31'd0, exit_err}, 32'd0);
    drive(1'b0, 1'b1, 3'd6);
    step();
    check("t4_exit_err", {31'd0, exit_err}, 32'd1);
    check("t4_free_count", {28'd0, free_count}, 32'd1);
    check("t4_pattern", {29'd0, pattern}, 32'h5);
    drive(1'b0, 1'b0, 3'd0);
    step();
    check("t4_exit_err_drop", {31'd0, exit_err}, 32'd0);

    // Drain the lot to rotate the pattern.
    do_reset();
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b101);
    step();
    drive(1'b0, 1'b0, 3'd0);
    step();
    step();
    drive(1'b0, 1'b1, 3'd0);
    step();
    check("t5_empty", {31'd0, empty}, 32'd1);
    check("t5_pattern", {29'd0, pattern}, 32'h3);
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b011);
    step();
    drive(1'b0, 1'b0, 3'd0);
    step();
    check("t5_tv", {31'd0, token_valid}, 32'd1);
    check("t5_pattern_hold", {29'd0, pattern}, 32'h3);

    // Exit for the slot being issued in the same cycle: error, allocation stands.
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b010);
    step();
    drive(1'b0, 1'b1, 3'd1);
    step();
    check("sim_tv", {31'd0, token_valid}, 32'd1);
    check("sim_exit_err", {31'd0, exit_err}, 32'd1);
    check("sim_free_count", {28'd0, free_count}, 32'd6);

    // Freeing slot 0 on the accept edge does not move the latched slot 2.
    drive(1'b1, 1'b1, 3'd0);
    sb.push_back(3'b001);
    step();
    check("latch_free_count", {28'd0, free_count}, 32'd7);
    check("latch_exit_err", {31'd0, exit_err}, 32'd0);
    drive(1'b0, 1'b0, 3'd0);
    step();
    check("latch_tv", {31'd0, token_valid}, 32'd1);
    check("latch_free_count2", {28'd0, free_count}, 32'd6);
    drive(1'b0, 1'b1, 3'd1);
    step();
    drive(1'b0, 1'b1, 3'd2);
    step();
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_pattern", {29'd0, pattern}, 32'h7);

    // Reset asserted while an allocation is in flight.
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b111);
    step();
    drive(1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 1'b0, 3'd0);
    step();
    drive(1'b0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_tv", {31'd0, token_valid}, 32'd0);
    check("mid_rst_free_count", {28'd0, free_count}, 32'd8);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_pattern", {29'd0, pattern}, 32'h5);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_tv", {31'd0, token_valid}, 32'd0);
    check("post_rst_free_count", {28'd0, free_count}, 32'd8);
    drive(1'b1, 1'b0, 3'd0);
    sb.push_back(3'b101);
    step();
    drive(1'b0, 1'b0, 3'd0);
    step();
    check("post_rst_issue_tv", {31'd0, token_valid}, 32'd1);
    check("post_rst_free_count2", {28'd0, free_count}, 32'd7);
    step();

    check("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
